// File: rtl/bus_ctrl_pkg.sv
// bus_ctrl_pkg: shared states, bus widths and tag extraction for the bus region controller
package bus_ctrl_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  typedef enum logic [1:0] {IDLE_WAIT, IDLE, ACCESS, RESP} state_t;
  function automatic logic [ADDR_W-1:0] tag_of(input logic [ADDR_W-1:0] addr, input int tag_width);
    return addr >> (ADDR_W - tag_width);
  endfunction
endpackage

// File: rtl/bus_region_decoder.sv
// bus_region_decoder: matches the address tag against the region tags, lowest index wins
module bus_region_decoder
  import bus_ctrl_pkg::*;
#(
  parameter int NUM_REGIONS = 3,
  parameter int TAG_WIDTH = 10,
  parameter logic [NUM_REGIONS*TAG_WIDTH-1:0] REGION_TAGS = {10'h2, 10'h1, 10'h0},
  localparam int IW = NUM_REGIONS > 1 ? $clog2(NUM_REGIONS) : 1
) (
  input  logic [ADDR_W-1:0]      addr,
  output logic                   hit,
  output logic [NUM_REGIONS-1:0] sel,
  output logic [IW-1:0]          idx
);
  logic [TAG_WIDTH-1:0] tag;
  assign tag = TAG_WIDTH'(tag_of(addr, TAG_WIDTH));
  always_comb begin
    hit = 1'b0;
    sel = '0;
    idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--)
      if (tag == REGION_TAGS[i*TAG_WIDTH +: TAG_WIDTH]) begin
        hit = 1'b1;
        sel = '0;
        sel[i] = 1'b1;
        idx = IW'(i);
      end
  end
endmodule

// File: rtl/bus_region_controller.sv
// bus_region_controller: one-at-a-time CPU request to tagged slave regions with timeout and error count
module bus_region_controller
  import bus_ctrl_pkg::*;
#(
  parameter int NUM_REGIONS = 3,
  parameter int TAG_WIDTH = 10,
  parameter logic [NUM_REGIONS*TAG_WIDTH-1:0] REGION_TAGS = {10'h2, 10'h1, 10'h0},
  parameter int TIMEOUT_CYCLES = 256,
  parameter int ERRCNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_W-1:0]             req_addr,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [DATA_W-1:0]             resp_data,
  output logic                          resp_err,
  output logic [NUM_REGIONS-1:0]        oen,
  input  logic [NUM_REGIONS*DATA_W-1:0] slave_data,
  input  logic [NUM_REGIONS-1:0]        slave_ready,
  output logic [ERRCNT_WIDTH-1:0]       err_count
);
  localparam int IW = NUM_REGIONS > 1 ? $clog2(NUM_REGIONS) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr_q, dec_addr;
  logic [NUM_REGIONS-1:0] sel;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] rdata;
  logic hit, rdy, tmo;
  // In IDLE the incoming address is decoded so the select can be latched on accept
  assign dec_addr = state == IDLE ? req_addr : addr_q;
  bus_region_decoder #(
    .NUM_REGIONS(NUM_REGIONS),
    .TAG_WIDTH(TAG_WIDTH),
    .REGION_TAGS(REGION_TAGS)
  ) u_dec (
    .addr(dec_addr),
    .hit(hit),
    .sel(sel),
    .idx(idx)
  );
  assign rdy = slave_ready[idx];
  assign rdata = slave_data[idx*DATA_W +: DATA_W];
  assign tmo = TIMEOUT_CYCLES > 0 && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_n = state;
    case (state)
      IDLE_WAIT: state_n = IDLE;
      IDLE:      state_n = !req_valid ? IDLE : hit ? ACCESS : RESP;
      ACCESS:    state_n = (rdy || tmo) ? RESP : ACCESS;
      RESP:      state_n = resp_ready ? IDLE : RESP;
      default:   state_n = IDLE_WAIT;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE_WAIT;
      req_ready <= 1'b0;
      resp_valid <= 1'b0;
      resp_data <= '0;
      resp_err <= 1'b0;
      oen <= '0;
      err_count <= '0;
      cnt <= '0;
      addr_q <= '0;
    end else begin
      state <= state_n;
      req_ready <= state_n == IDLE;
      resp_valid <= state_n == RESP;
      oen <= state_n == ACCESS ? sel : '0;
      if (state == IDLE && req_valid) begin
        addr_q <= req_addr;
        resp_data <= '0;
        resp_err <= !hit;
      end
      if (state == ACCESS) begin
        cnt <= cnt + 1'b1;
        if (state_n == RESP) begin
          resp_data <= rdy ? rdata : '0;
          resp_err <= !rdy;
        end
      end
      if (state == RESP && resp_ready) begin
        cnt <= '0;
        if (resp_err && err_count != '1) err_count <= err_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bus_region_controller.sv
// tb_bus_region_controller: directed checks of decode, latency, timeout, stall, saturation and async reset
module tb_bus_region_controller;
  logic clk = 1'b0, rst = 1'b0, req_valid = 1'b0, req_ready, resp_valid, resp_ready = 1'b0, resp_err;
  logic [31:0] req_addr = '0, resp_data;
  logic [2:0] oen, slave_ready = '0;
  logic [95:0] slave_data = '0;
  logic [1:0] err_count;
  int errors = 0, checks = 0;
  bus_region_controller #(.TIMEOUT_CYCLES(4), .ERRCNT_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .oen(oen), .slave_data(slave_data), .slave_ready(slave_ready), .err_count(err_count)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic handshake;
    resp_ready = 1'b1;
    step;
    resp_ready = 1'b0;
    chk("hs_valid", 32'(resp_valid), 32'd0);
    chk("hs_ready", 32'(req_ready), 32'd1);
  endtask
  initial begin
    step;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_oen", 32'(oen), 32'd0);
    chk("rst_data", resp_data, 32'd0);
    chk("rst_errcnt", 32'(err_count), 32'd0);
    rst = 1'b1;
    step;
    chk("idle_ready", 32'(req_ready), 32'd1);
    // region 0, ready in third access cycle
    req_valid = 1'b1;
    req_addr = 32'h0000_0040;
    step;
    req_valid = 1'b0;
    req_addr = 32'hFFC0_0000;
    chk("r0_oen1", 32'(oen), 32'h1);
    chk("r0_busy", 32'(req_ready), 32'd0);
    step;
    chk("r0_oen2", 32'(oen), 32'h1);
    step;
    chk("r0_oen3", 32'(oen), 32'h1);
    chk("r0_novalid", 32'(resp_valid), 32'd0);
    slave_ready = 3'b001;
    slave_data[0 +: 32] = 32'hDEAD_BEEF;
    step;
    slave_ready = 3'b000;
    chk("r0_oen_off", 32'(oen), 32'h0);
    chk("r0_valid", 32'(resp_valid), 32'd1);
    chk("r0_data", resp_data, 32'hDEAD_BEEF);
    chk("r0_err", 32'(resp_err), 32'd0);
    handshake;
    chk("r0_errcnt", 32'(err_count), 32'd0);
    // region 1, ready immediately
    slave_ready = 3'b010;
    slave_data[32 +: 32] = 32'h1234_5678;
    req_valid = 1'b1;
    req_addr = 32'h0040_0000;
    step;
    req_valid = 1'b0;
    chk("r1_oen", 32'(oen), 32'h2);
    chk("r1_early", 32'(resp_valid), 32'd0);
    step;
    slave_ready = 3'b000;
    chk("r1_valid", 32'(resp_valid), 32'd1);
    chk("r1_data", resp_data, 32'h1234_5678);
    chk("r1_oen_off", 32'(oen), 32'h0);
    handshake;
    // unmapped
    req_valid = 1'b1;
    req_addr = 32'hFFC0_0000;
    step;
    req_valid = 1'b0;
    chk("um_oen", 32'(oen), 32'h0);
    chk("um_valid", 32'(resp_valid), 32'd1);
    chk("um_err", 32'(resp_err), 32'd1);
    chk("um_data", resp_data, 32'd0);
    handshake;
    chk("um_errcnt", 32'(err_count), 32'd1);
    // region 2 timeout, non-selected ready ignored
    slave_ready = 3'b011;
    req_valid = 1'b1;
    req_addr = 32'h0080_0000;
    step;
    for (int i = 0; i < 4; i++) begin
      chk("to_oen", 32'(oen), 32'h4);
      chk("to_novalid", 32'(resp_valid), 32'd0);
      step;
    end
    slave_ready = 3'b000;
    chk("to_valid", 32'(resp_valid), 32'd1);
    chk("to_err", 32'(resp_err), 32'd1);
    chk("to_data", resp_data, 32'd0);
    chk("to_oen_off", 32'(oen), 32'h0);
    // response stall with a pending request
    for (int i = 0; i < 5; i++) begin
      step;
      chk("st_valid", 32'(resp_valid), 32'd1);
      chk("st_err", 32'(resp_err), 32'd1);
      chk("st_data", resp_data, 32'd0);
      chk("st_ready", 32'(req_ready), 32'd0);
    end
    handshake;
    chk("to_errcnt", 32'(err_count), 32'd2);
    // second run: ready in the fourth access cycle wins over timeout
    step;
    req_valid = 1'b0;
    chk("rt_oen1", 32'(oen), 32'h4);
    step;
    step;
    step;
    chk("rt_oen4", 32'(oen), 32'h4);
    slave_ready = 3'b100;
    slave_data[64 +: 32] = 32'hCAFE_F00D;
    step;
    slave_ready = 3'b000;
    chk("rt_valid", 32'(resp_valid), 32'd1);
    chk("rt_err", 32'(resp_err), 32'd0);
    chk("rt_data", resp_data, 32'hCAFE_F00D);
    handshake;
    chk("rt_errcnt", 32'(err_count), 32'd2);
    // saturating error counter
    for (int i = 0; i < 2; i++) begin
      req_valid = 1'b1;
      req_addr = 32'h00C0_0000;
      step;
      req_valid = 1'b0;
      chk("sat_err", 32'(resp_err), 32'd1);
      handshake;
      chk("sat_errcnt", 32'(err_count), 32'd3);
    end
    // asynchronous reset mid-access
    req_valid = 1'b1;
    req_addr = 32'h0000_0040;
    step;
    req_valid = 1'b0;
    chk("ar_oen", 32'(oen), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_oen_off", 32'(oen), 32'h0);
    chk("ar_valid", 32'(resp_valid), 32'd0);
    chk("ar_ready", 32'(req_ready), 32'd0);
    chk("ar_errcnt", 32'(err_count), 32'd0);
    step;
    rst = 1'b1;
    chk("ar_wait", 32'(req_ready), 32'd0);
    step;
    chk("ar_idle", 32'(req_ready), 32'd1);
    chk("ar_noresp", 32'(resp_valid), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
